pipe_mux_nx1: RTL and testbench

//   Parametrised, registered W-bit N:1 selector with valid/ready handshake on both sides.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_nx1.sv | 36 +++
 rtl/pipe_mux_nx1.sv | 124 ++++++++++++
 tb/tb_pipe_mux_nx1.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N:1 selector.
//   state_e     : EMPTY / ONE / FULL occupancy of the main (M) and skid (S) registers
//   DEF_WIDTH   : default data width
//   clog2_min1  : select width for a given input count, never below 1
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 32;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational W-bit N:1 select with out-of-range detection.
//   in_data  : packed inputs, input i = in_data[i*WIDTH +: WIDTH]
//   sel      : input index
//   out_data : selected word
//   sel_err  : sel >= NUM_IN (only meaningful when MUX_SEL_CHECK_EN is defined)
// Build option MUX_SEL_CHECK_EN: out-of-range select yields all-zeros and
// raises sel_err; otherwise it yields input 0 and sel_err is tied low.
module mux_nx1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err
);

    always_comb begin
`ifdef MUX_SEL_CHECK_EN
        out_data = '0;
        sel_err  = (32'(sel) >= NUM_IN);
`else
        out_data = in_data[WIDTH-1:0];
        sel_err  = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                out_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pipe_mux_nx1.sv
// Registered W-bit N:1 selector with valid/ready on both sides and a
// 2-entry skid buffer (main register M, skid register S) for full throughput.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : synchronous discard of all held entries
//   in_data/in_sel     : packed inputs and index, sampled on accept
//   in_valid/in_ready  : upstream handshake (in_ready is registered)
//   out_data/out_valid : selected word held in M
//   out_ready          : downstream handshake
//   sel_err            : sticky out-of-range select flag
// Build option MUX_SEL_CHECK_EN enables out-of-range zeroing and sel_err.
module pipe_mux_nx1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;
    logic             drain;

    mux_nx1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (in_data),
        .sel      (in_sel),
        .out_data (mux_data),
        .sel_err  (mux_err)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        s_d       = s_q;
        sel_err_d = sel_err_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            if (accept && mux_err) begin
                sel_err_d = 1'b1;
            end
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        m_d     = mux_data;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_d = FULL;
                        s_d     = mux_data;
                    end else if (accept && drain) begin
                        m_d     = mux_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d = ONE;
                        m_d     = s_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Handshake outputs are registered copies of the next-state decode,
        // so out_ready never reaches in_ready combinationally.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_nx1.sv
module tb_pipe_mux_nx1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT0: WIDTH=32, NUM_IN=4
    logic         flush0 = 1'b0;
    logic [127:0] in_data0 = '0;
    logic [1:0]   in_sel0 = '0;
    logic         in_valid0 = 1'b0;
    logic         in_ready0;
    logic [31:0]  out_data0;
    logic         out_valid0;
    logic         out_ready0 = 1'b0;
    logic         sel_err0;

    // DUT1: WIDTH=8, NUM_IN=3 (non power of two)
    logic         flush1 = 1'b0;
    logic [23:0]  in_data1 = '0;
    logic [1:0]   in_sel1 = '0;
    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [7:0]   out_data1;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic         sel_err1;

    int checks = 0;
    int failures = 0;

    pipe_mux_nx1 #(.WIDTH(32), .NUM_IN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0),
        .in_data(in_data0), .in_sel(in_sel0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .sel_err(sel_err0)
    );

    pipe_mux_nx1 #(.WIDTH(8), .NUM_IN(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .in_data(in_data1), .in_sel(in_sel1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .sel_err(sel_err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // put an entry in flight, then reset between edges
        in_data0 = {32'h4, 32'h3, 32'h2, 32'h1};
        in_sel0 = 2'd3; in_valid0 = 1'b1; out_ready0 = 1'b0;
        step();
        in_valid0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid0); end
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready0); end
        checks++; if (out_data0 !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data0); end
        checks++; if (sel_err0 !== 1'b0) begin failures++; $display("FAIL reset_sel_err got=%0b exp=0", sel_err0); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_select();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hC; exp_seq[3] = 32'hD;
        in_data0 = {32'hD, 32'hC, 32'hB, 32'hA};
        in_sel0 = 2'd2; in_valid0 = 1'b1; out_ready0 = 1'b1;
        step();
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'hC)
            begin failures++; $display("FAIL sel2 got v=%0b d=%h exp v=1 d=0000000c", out_valid0, out_data0); end
        for (int i = 0; i < 4; i++) begin
            in_sel0 = 2'(i);
            step();
            checks++; if (out_valid0 !== 1'b1 || out_data0 !== exp_seq[i] || in_ready0 !== 1'b1)
                begin failures++; $display("FAIL stream_%0d got v=%0b d=%h r=%0b exp v=1 d=%h r=1", i, out_valid0, out_data0, in_ready0, exp_seq[i]); end
        end
        in_valid0 = 1'b0;
        step();
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%0b exp=0", out_valid0); end
    endtask

    task automatic test_backpressure();
        out_ready0 = 1'b0; in_sel0 = 2'd1; in_valid0 = 1'b1;
        in_data0 = {4{32'h11}};
        step();
        checks++; if (out_data0 !== 32'h11 || in_ready0 !== 1'b1)
            begin failures++; $display("FAIL bp_first got d=%h r=%0b exp d=00000011 r=1", out_data0, in_ready0); end
        in_data0 = {4{32'h22}};
        step();
        checks++; if (in_ready0 !== 1'b0 || out_data0 !== 32'h11)
            begin failures++; $display("FAIL bp_full got r=%0b d=%h exp r=0 d=00000011", in_ready0, out_data0); end
        in_data0 = {4{32'h33}};
        step();
        checks++; if (in_ready0 !== 1'b0 || out_data0 !== 32'h11 || out_valid0 !== 1'b1)
            begin failures++; $display("FAIL bp_third_offer got r=%0b d=%h v=%0b exp r=0 d=00000011 v=1", in_ready0, out_data0, out_valid0); end
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        step();
        checks++; if (out_data0 !== 32'h22 || out_valid0 !== 1'b1 || in_ready0 !== 1'b1)
            begin failures++; $display("FAIL bp_second_out got d=%h v=%0b r=%0b exp d=00000022 v=1 r=1", out_data0, out_valid0, in_ready0); end
        step();
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL bp_empty got v=%0b exp=0", out_valid0); end
    endtask

    task automatic test_flush();
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_sel0 = 2'd0;
        in_data0 = {4{32'h44}};
        step();
        in_data0 = {4{32'h55}};
        step();
        in_data0 = {4{32'h33}};
        in_valid0 = 1'b1; flush0 = 1'b1;
        step();
        checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1)
            begin failures++; $display("FAIL flush_state got v=%0b r=%0b exp v=0 r=1", out_valid0, in_ready0); end
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid0 !== 1'b0)
                begin failures++; $display("FAIL flush_no_ghost_%0d got v=%0b d=%h exp v=0", i, out_valid0, out_data0); end
        end
    endtask

    task automatic test_sel_range();
        logic [7:0] exp_d;
        logic       exp_e;
`ifdef MUX_SEL_CHECK_EN
        exp_d = 8'h00; exp_e = 1'b1;
`else
        exp_d = 8'h10; exp_e = 1'b0;
`endif
        in_data1 = {8'h30, 8'h20, 8'h10};
        in_sel1 = 2'd3; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== exp_d || sel_err1 !== exp_e)
            begin failures++; $display("FAIL oor_sel got v=%0b d=%h e=%0b exp v=1 d=%h e=%0b", out_valid1, out_data1, sel_err1, exp_d, exp_e); end
        in_valid1 = 1'b0; flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        checks++; if (sel_err1 !== exp_e || out_valid1 !== 1'b0)
            begin failures++; $display("FAIL oor_after_flush got e=%0b v=%0b exp e=%0b v=0", sel_err1, out_valid1, exp_e); end
        in_sel1 = 2'd1; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        checks++; if (out_data1 !== 8'h20 || sel_err1 !== exp_e)
            begin failures++; $display("FAIL inrange_after_err got d=%h e=%0b exp d=20 e=%0b", out_data1, sel_err1, exp_e); end
        step();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_w;
        logic [31:0] prev_d;
        logic        prev_stall;
        logic        acc, drn;
        int          rnd_fail;
        prev_stall = 1'b0; prev_d = '0; rnd_fail = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid0 = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
            in_sel0 = 2'($urandom_range(0, 3));
            in_data0 = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (out_valid0 !== (q.size() != 0) || in_ready0 !== (q.size() < 2)) begin
                failures++; rnd_fail++;
                if (rnd_fail < 10) $display("FAIL rnd_occupancy cyc=%0d got v=%0b r=%0b exp entries=%0d", c, out_valid0, in_ready0, q.size());
            end
            if (prev_stall) begin
                checks++;
                if (out_valid0 !== 1'b1 || out_data0 !== prev_d) begin
                    failures++; rnd_fail++;
                    if (rnd_fail < 10) $display("FAIL rnd_stall_stable cyc=%0d got v=%0b d=%h exp v=1 d=%h", c, out_valid0, out_data0, prev_d);
                end
            end
            acc = in_valid0 && (q.size() < 2);
            drn = out_ready0 && (q.size() != 0);
            if (drn) begin
                exp_w = q.pop_front();
                checks++;
                if (out_data0 !== exp_w) begin
                    failures++; rnd_fail++;
                    if (rnd_fail < 10) $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c, out_data0, exp_w);
                end
            end
            if (acc) q.push_back(in_data0[in_sel0*32 +: 32]);
            prev_stall = out_valid0 && !out_ready0;
            prev_d = out_data0;
            step();
        end
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        for (int c = 0; c < 4 && q.size() != 0; c++) begin
            #1;
            exp_w = q.pop_front();
            checks++;
            if (out_valid0 !== 1'b1 || out_data0 !== exp_w) begin
                failures++; $display("FAIL rnd_drain got v=%0b d=%h exp v=1 d=%h", out_valid0, out_data0, exp_w);
            end
            step();
        end
        #1;
        checks++;
        if (q.size() != 0 || out_valid0 !== 1'b0) begin
            failures++; $display("FAIL rnd_final got v=%0b left=%0d exp v=0 left=0", out_valid0, q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        test_reset();
        test_select();
        test_backpressure();
        test_flush();
        test_sel_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
